// File: rtl/if_fetch_stage_if.sv
// Bundle of the fetch stage's bus-facing signals: redirect input, decode
// handshake and the instruction-memory read port.
interface if_fetch_stage_if #(
  parameter int ISIZE = 32,
  parameter int DSIZE = 32
);
  // Redirect from the branch-resolution logic.
  logic             redirect;
  logic [ISIZE-1:0] redirect_pc;

  // Decode-side handshake.
  logic             id_ready;
  logic             if_valid;
  logic [DSIZE-1:0] if_inst;
  logic [ISIZE-1:0] if_pc;

  // Instruction-memory read port (data returns one cycle after imem_en).
  logic             imem_en;
  logic [ISIZE-1:0] imem_addr;
  logic [DSIZE-1:0] imem_data;

  // The fetch stage itself.
  modport master (
    input  redirect, redirect_pc, id_ready, imem_data,
    output imem_en, imem_addr, if_valid, if_inst, if_pc
  );

  // The environment around it: decode, branch unit and instruction memory.
  modport slave (
    output redirect, redirect_pc, id_ready, imem_data,
    input  imem_en, imem_addr, if_valid, if_inst, if_pc
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, issues reads to a 1-cycle
// instruction memory and buffers {pc, inst} in a small prefetch FIFO for decode.
module if_fetch_stage #(
  parameter int               ISIZE    = 32,
  parameter int               DSIZE    = 32,
  parameter int               DEPTH    = 2,
  parameter logic [ISIZE-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  if_fetch_stage_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [ISIZE-1:0] pc;
    logic [DSIZE-1:0] inst;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [ISIZE-1:0] fpc;
  logic [ISIZE-1:0] tag;
  logic             inflight;

  logic             valid;
  logic             pop;
  logic             push;
  logic             issue;
  logic [OW-1:0]    occupancy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Occupancy counts the in-flight word too, so issuing never lets the FIFO
  // overrun; a pop in the same cycle frees a slot early.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid     = 1'b0;
    pop       = 1'b0;
    push      = 1'b0;
    issue     = 1'b0;
    occupancy = '0;
    if (!rst) begin
      valid     = (count != '0);
      pop       = valid && bus.id_ready;
      push      = inflight && !bus.redirect;
      occupancy = OW'(count) + OW'(inflight) - OW'(pop);
      issue     = !bus.redirect && (occupancy < OW'(DEPTH));
    end
  end

  assign bus.imem_en   = issue;
  assign bus.imem_addr = fpc;
  assign bus.if_valid  = valid;
  assign bus.if_inst   = valid ? mem[rd_ptr].inst : '0;
  assign bus.if_pc     = valid ? mem[rd_ptr].pc   : '0;

  // Redirect outranks pop/push: the queue is emptied and the word returning
  // for the old stream is dropped on the floor.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc      <= RESET_PC;
      tag      <= '0;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (bus.redirect) begin
      fpc      <= bus.redirect_pc;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fpc <= fpc + 1'b1;
        tag <= fpc;
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: the FIFO storage has no reset; count gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= '{pc: tag, inst: bus.imem_data};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count == CW'(DEPTH)));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage: a queue-level model of the fetch
// pipeline plus a consecutive-PC scoreboard, with literal timing pins.
module tb_if_fetch_stage;
  localparam int          ISIZE    = 32;
  localparam int          DSIZE    = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_stage_if #(.ISIZE(ISIZE), .DSIZE(DSIZE)) bus ();

  if_fetch_stage #(
    .ISIZE(ISIZE), .DSIZE(DSIZE), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: queue of buffered PCs, one optional in-flight fetch, next fetch PC.
  logic [31:0] m_q[$];
  logic        m_infl   = 1'b0;
  logic [31:0] m_tag    = '0;
  logic [31:0] m_fpc    = '0;
  logic        m_valid  = 1'b0;
  logic        m_pop    = 1'b0;
  logic        m_en     = 1'b0;
  logic [31:0] exp_next = '0;

  // Inputs of the current cycle, and the memory request seen last cycle.
  logic        c_rst = 1'b1, c_redir = 1'b0, c_rdy = 1'b0;
  logic [31:0] c_rpc = '0;
  logic        prev_en = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs at the falling edge, then compare outputs against the model.
  task automatic drive(input logic rs, input logic rd, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    c_rst = rs; c_redir = rd; c_rpc = rpc; c_rdy = rdy;
    rst = rs;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.id_ready    = rdy;
    bus.imem_data   = prev_en ? word_at(prev_addr) : $urandom;
    #1;
    m_valid = !rs && (m_q.size() != 0);
    m_pop   = m_valid && rdy;
    m_en    = !rs && !rd && ((m_q.size() + int'(m_infl) - int'(m_pop)) < DEPTH);
    check("if_valid", 64'(bus.if_valid), 64'(m_valid));
    check("if_pc",    64'(bus.if_pc),    m_valid ? 64'(m_q[0]) : 64'h0);
    check("if_inst",  64'(bus.if_inst),  m_valid ? 64'(word_at(m_q[0])) : 64'h0);
    check("imem_en",  64'(bus.imem_en),  64'(m_en));
    if (!rs) check("imem_addr", 64'(bus.imem_addr), 64'(m_fpc));
    if (m_pop && !rd) begin
      check("accept_seq", 64'(bus.if_pc), 64'(exp_next));
      exp_next = exp_next + 1;
    end
    prev_en   = bus.imem_en;
    prev_addr = bus.imem_addr;
  endtask

  task automatic tick();
    @(posedge clk);
    if (c_rst) begin
      m_q.delete(); m_infl = 1'b0; m_fpc = RESET_PC; exp_next = RESET_PC;
    end else if (c_redir) begin
      m_q.delete(); m_infl = 1'b0; m_fpc = c_rpc; exp_next = c_rpc;
    end else begin
      if (m_pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_tag);
      m_infl = m_en;
      if (m_en) begin
        m_tag = m_fpc;
        m_fpc = m_fpc + 1;
      end
    end
  endtask

  task automatic step(input logic rs, input logic rd, input logic [31:0] rpc, input logic rdy);
    drive(rs, rd, rpc, rdy);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0; bus.imem_data = '0;

    // Reset then stream from RESET_PC.
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1_first_addr", 64'(bus.imem_addr), 64'h0);
    check("t1_first_en",   64'(bus.imem_en),   64'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1_not_yet_valid", 64'(bus.if_valid), 64'h0);
    check("t1_addr1", 64'(bus.imem_addr), 64'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1_valid_rise", 64'(bus.if_valid), 64'h1);
    check("t1_pc0",   64'(bus.if_pc),   64'h0);
    check("t1_inst0", 64'(bus.if_inst), 64'hA000_0000);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1_pc1",   64'(bus.if_pc),   64'h1);
    check("t1_inst1", 64'(bus.if_inst), 64'hA000_0001);
    tick();
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Decode stall: fetch backs off once two words are owed.
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("t2_stall_en_low", 64'(bus.imem_en), 64'h0);
    tick();
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect to 0x40 right after a stall cycle, with words buffered and in flight.
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t3_flushed", 64'(bus.if_valid), 64'h0);
    check("t3_addr40",  64'(bus.imem_addr), 64'h40);
    tick();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      check("t3_pc", 64'(bus.if_pc), 64'(32'h40 + k));
      tick();
    end

    // Redirect near the top of the address space: PC wraps to zero.
    step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_pc_fffffffe", 64'(bus.if_pc), 64'hFFFF_FFFE);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_pc_ffffffff", 64'(bus.if_pc), 64'hFFFF_FFFF);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_pc_wrap0", 64'(bus.if_pc), 64'h0);
    check("t4_inst_wrap0", 64'(bus.if_inst), 64'hA000_0000);
    tick();
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset together with redirect: reset wins, redirect_pc is ignored.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 32'h1234, 1'b1);
      check("t5_valid_low_in_rst", 64'(bus.if_valid), 64'h0);
      tick();
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t5_restart_pc", 64'(bus.if_pc), 64'(RESET_PC));
    tick();

    // Random back-pressure.
    for (int i = 0; i < 1000; i++)
      step(1'b0, 1'b0, 32'h0, 1'($urandom_range(0, 1)));

    // Random back-pressure with occasional redirects, some near the wrap point.
    for (int i = 0; i < 600; i++) begin
      logic        rd;
      logic [31:0] rpc;
      rd  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
      step(1'b0, rd, rpc, 1'($urandom_range(0, 1)));
    end
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
